program_memory_loader: RTL and testbench

// Writer side of the instruction store. Receives the program as a byte stream
// (valid/ready), packs four bytes big-endian into one 32-bit instruction word and

---
 rtl/program_memory_loader.sv | 148 ++++++++++++++
 tb/tb_program_memory_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - byte-stream to 32-bit instruction word loader for the instruction RAM
module program_memory_loader #(
  parameter int                    MEMORY_DEPTH   = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS   = DATA_WIDTH'(32'h0040_0000),
  parameter int                    TIMEOUT_CYCLES = 1024,
  localparam int                   CW             = $clog2(MEMORY_DEPTH) + 1,
  localparam int                   TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [CW-1:0]         i_word_count,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_write_enable,
  output logic [DATA_WIDTH-1:0] o_write_address,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_word_count;
  logic [CW-1:0]   r_words;
  logic [1:0]      r_byte_idx;
  logic [23:0]     r_partial;
  logic [TW-1:0]   r_timeout;

  logic            w_accept;
  logic            w_too_many;
  logic [CW-1:0]   w_words_next;
  logic            w_timeout_hit;

  // o_byte_ready is itself a register, so the handshake never depends
  // combinationally on i_byte_valid.
  assign w_accept      = (r_state == S_COLLECT) && o_byte_ready && i_byte_valid;
  assign w_too_many    = (int'(i_word_count) > MEMORY_DEPTH);
  assign w_words_next  = r_words + CW'(1);
  assign w_timeout_hit = (r_timeout == TW'(TIMEOUT_CYCLES - 1));

  // Loader FSM: every output is registered and updated on the transition
  // into the state it belongs to, so it is valid for the whole state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_word_count    <= '0;
      r_words         <= '0;
      r_byte_idx      <= '0;
      r_partial       <= '0;
      r_timeout       <= '0;
      o_byte_ready    <= 1'b0;
      o_write_enable  <= 1'b0;
      o_write_address <= BASE_ADDRESS;
      o_write_data    <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      o_write_enable <= 1'b0;
      o_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_word_count <= i_word_count;
            o_error      <= 1'b0;
            o_busy       <= 1'b1;
            if (i_word_count == '0) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end else if (w_too_many) begin
              // Oversized programs are rejected up front, nothing is written.
              r_state <= S_DONE;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else begin
              r_state         <= S_COLLECT;
              o_byte_ready    <= 1'b1;
              o_write_address <= BASE_ADDRESS;
              r_words         <= '0;
              r_byte_idx      <= '0;
              r_timeout       <= '0;
            end
          end
        end

        S_COLLECT: begin
          if (w_accept) begin
            r_timeout <= '0;
            if (r_byte_idx == 2'd3) begin
              // First byte received ends up in the most significant lane.
              o_write_data   <= {r_partial, i_byte_in};
              o_write_enable <= 1'b1;
              o_byte_ready   <= 1'b0;
              r_state        <= S_WRITE;
              r_byte_idx     <= '0;
            end else begin
              r_partial  <= {r_partial[15:0], i_byte_in};
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end else if (w_timeout_hit) begin
            // Stream stalled: abandon the partial word without writing it.
            o_byte_ready <= 1'b0;
            o_error      <= 1'b1;
            o_done       <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_timeout <= r_timeout + TW'(1);
          end
        end

        S_WRITE: begin
          o_write_address <= o_write_address + DATA_WIDTH'(4);
          r_words         <= w_words_next;
          if (w_words_next == r_word_count) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end else begin
            r_state      <= S_COLLECT;
            o_byte_ready <= 1'b1;
            r_timeout    <= '0;
          end
        end

        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state      <= S_IDLE;
          o_busy       <= 1'b0;
          o_byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - randomized self-checking bench for program_memory_loader
module tb_program_memory_loader;

  localparam int          DEPTH = 32;
  localparam int          TOUT  = 1024;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        write_enable;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  program_memory_loader dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_word_count    (word_count),
    .i_byte_in       (byte_in),
    .i_byte_valid    (byte_valid),
    .o_byte_ready    (byte_ready),
    .o_write_enable  (write_enable),
    .o_write_address (write_address),
    .o_write_data    (write_data),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error)
  );

  always #5 clk = ~clk;

  // Observed RAM writes {address, data}, Done pulses and ready cycles.
  logic [63:0] wr_q[$];
  int done_cnt = 0;
  int done_run = 0;
  int done_run_max = 0;
  int ready_cycles = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (write_enable) wr_q.push_back({write_address, write_data});
      if (done) begin
        done_cnt = done_cnt + 1;
        done_run = done_run + 1;
        if (done_run > done_run_max) done_run_max = done_run;
      end else begin
        done_run = 0;
      end
      if (byte_ready) ready_cycles = ready_cycles + 1;
    end
  end

  // Program bytes for the current load and the reference image derived from them.
  logic [7:0] tx_q[$];

  function automatic logic [63:0] ref_word(input int k);
    logic [31:0] a;
    logic [31:0] d;
    a = BASE + 32'(4 * k);
    d = {tx_q[4*k], tx_q[4*k+1], tx_q[4*k+2], tx_q[4*k+3]};
    return {a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    word_count = 6'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    word_count = 6'($urandom_range(63, 0));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax, input bit noise);
    int g;
    int guard;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) tick();
    byte_in = b;
    byte_valid = 1'b1;
    if (noise) begin
      start = $urandom_range(1, 0) != 0;
      word_count = 6'($urandom_range(63, 0));
    end
    guard = 0;
    while (!byte_ready && guard < 3000) begin
      tick();
      guard++;
      if (noise) start = $urandom_range(1, 0) != 0;
    end
    checks++;
    if (guard >= 3000) begin
      errors++;
      $display("FAIL byte_accept: ready never seen for byte %02h, waited %0d cycles, required < 3000", b, guard);
    end
    tick();
    byte_valid = 1'b0;
    start = 1'b0;
    byte_in = 8'($urandom_range(255, 0));
  endtask

  task automatic wait_done(input int d0, input int budget, output int cycles);
    cycles = 0;
    while (done_cnt == d0 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_load(input int n, input int gapmax, input bit noise);
    int cyc;
    int d0;
    wr_q.delete();
    done_run_max = 0;
    d0 = done_cnt;
    pulse_start(n);
    foreach (tx_q[i]) send_byte(tx_q[i], gapmax, noise);
    wait_done(d0, 50, cyc);
    tick();
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL load_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic fill_random(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic test_reset();
    checks++;
    if ({byte_ready, write_enable, busy, done, error} !== 5'b0 ||
        write_data !== 32'h0 || write_address !== BASE) begin
      errors++;
      $display("FAIL reset_state: rdy/we/busy/done/err=%b data=%h addr=%h, required 00000 00000000 %h",
               {byte_ready, write_enable, busy, done, error}, write_data, write_address, BASE);
    end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    run_load(2, 0, 1'b0);
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d writes, required 2", wr_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = ref_word(k);
        checks++;
        if (wr_q[k] !== e) begin
          errors++;
          $display("FAIL basic_word%0d: got addr %h data %h, required addr %h data %h",
                   k, wr_q[k][63:32], wr_q[k][31:0], e[63:32], e[31:0]);
        end
      end
    end
    checks++;
    if (error !== 1'b0 || done_run_max != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: error=%b done_width=%0d busy=%b, required 0 1 0", error, done_run_max, busy);
    end
  endtask

  task automatic test_zero_count();
    int cyc;
    int d0;
    wr_q.delete();
    d0 = done_cnt;
    pulse_start(0);
    wait_done(d0, 10, cyc);
    checks++;
    if (done_cnt != d0 + 1 || cyc > 2 || wr_q.size() != 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: done=%0d after %0d cycles, writes=%0d error=%b, required 1 within 2, 0, 0",
               done_cnt - d0, cyc, wr_q.size(), error);
    end
  endtask

  task automatic test_overflow(input int n);
    int cyc;
    int d0;
    int r0;
    wr_q.delete();
    d0 = done_cnt;
    r0 = ready_cycles;
    pulse_start(n);
    wait_done(d0, 10, cyc);
    repeat (4) tick();
    checks++;
    if (error !== 1'b1 || done_cnt != d0 + 1 || wr_q.size() != 0 || ready_cycles != r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_%0d: error=%b done=%0d writes=%0d ready_cycles=%0d busy=%b, required 1 1 0 0 0",
               n, error, done_cnt - d0, wr_q.size(), ready_cycles - r0, busy);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int d0;
    fill_random(8);
    wr_q.delete();
    d0 = done_cnt;
    pulse_start(2);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_clears_error: error=%b busy=%b ready=%b, required 0 1 1", error, busy, byte_ready);
    end
    for (int i = 0; i < 3; i++) send_byte(tx_q[i], 3, 1'b0);
    wait_done(d0, TOUT + 20, cyc);
    checks++;
    if (done_cnt != d0 + 1 || cyc < TOUT - 2 || cyc > TOUT + 3) begin
      errors++;
      $display("FAIL timeout_timing: done=%0d after %0d idle cycles, required 1 after about %0d", done_cnt - d0, cyc, TOUT);
    end
    repeat (5) tick();
    checks++;
    if (error !== 1'b1 || wr_q.size() != 0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: error=%b writes=%0d ready=%b, required 1 0 0", error, wr_q.size(), byte_ready);
    end
  endtask

  task automatic test_random_loads(input int n, input int gapmax, input bit noise);
    logic [63:0] e;
    int bad;
    fill_random(4 * n);
    run_load(n, gapmax, noise);
    checks++;
    if (wr_q.size() != n) begin
      errors++;
      $display("FAIL random_write_count n=%0d: got %0d writes, required %0d", n, wr_q.size(), n);
    end else begin
      bad = 0;
      for (int k = 0; k < n; k++) begin
        e = ref_word(k);
        if (wr_q[k] !== e && bad == 0) begin
          bad = 1;
          $display("FAIL random_word n=%0d k=%0d: got addr %h data %h, required addr %h data %h",
                   n, k, wr_q[k][63:32], wr_q[k][31:0], e[63:32], e[31:0]);
        end
      end
      checks++;
      errors += bad;
    end
    checks++;
    if (error !== 1'b0 || done_run_max != 1) begin
      errors++;
      $display("FAIL random_status n=%0d: error=%b done_width=%0d, required 0 1", n, error, done_run_max);
    end
  endtask

  task automatic test_reset_midload();
    logic [63:0] e;
    fill_random(16);
    wr_q.delete();
    pulse_start(4);
    for (int i = 0; i < 10; i++) send_byte(tx_q[i], 2, 1'b0);
    tick();
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL midload_writes: got %0d writes before reset, required 2", wr_q.size());
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, write_enable, busy, done, error} !== 5'b0 ||
        write_data !== 32'h0 || write_address !== BASE) begin
      errors++;
      $display("FAIL async_reset: rdy/we/busy/done/err=%b data=%h addr=%h, required 00000 00000000 %h",
               {byte_ready, write_enable, busy, done, error}, write_data, write_address, BASE);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_load(4, 1, 1'b0);
    checks++;
    if (wr_q.size() != 4) begin
      errors++;
      $display("FAIL reload_count: got %0d writes, required 4", wr_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = ref_word(k);
        checks++;
        if (wr_q[k] !== e) begin
          errors++;
          $display("FAIL reload_word%0d: got addr %h data %h, required addr %h data %h",
                   k, wr_q[k][63:32], wr_q[k][31:0], e[63:32], e[31:0]);
        end
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow(DEPTH + 1);
    test_overflow(63);
    test_timeout();
    test_random_loads(1, 0, 1'b0);
    test_random_loads(3, 0, 1'b0);
    test_random_loads(5, 6, 1'b1);
    test_random_loads(int'($urandom_range(DEPTH, 2)), 4, 1'b1);
    test_random_loads(DEPTH, 0, 1'b0);
    test_random_loads(DEPTH, 3, 1'b1);
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
